// File: rtl/egress_scheduler_if.sv
// Port bundle for egress_scheduler: per-ingress request/data strobes in,
// grant/ownership/status out, plus FSM and round-robin pointer debug taps.
interface egress_scheduler_if #(
    parameter int NUM_PORTS = 4
);
    // Strobes are level-qualified per cycle: dest is meaningful only while the
    // matching dest_valid bit is 1, in_eop only while in_valid is 1; there is
    // no backpressure, every asserted strobe is consumed in its cycle.
    logic [NUM_PORTS-1:0]      dest_valid;
    logic [NUM_PORTS-1:0][1:0] dest;
    logic [NUM_PORTS-1:0]      in_valid;
    logic [NUM_PORTS-1:0]      in_eop;
    logic [NUM_PORTS-1:0]      grant;
    logic [NUM_PORTS-1:0]      egress_busy;
    logic [NUM_PORTS-1:0][1:0] egress_owner;
    logic [NUM_PORTS-1:0]      timeout_err;
    logic [NUM_PORTS-1:0]      drop;
    logic [NUM_PORTS-1:0][1:0] dbg_state;
    logic [NUM_PORTS-1:0][1:0] dbg_rr_ptr;

    modport master (
        output dest_valid, dest, in_valid, in_eop,
        input  grant, egress_busy, egress_owner, timeout_err, drop,
        input  dbg_state, dbg_rr_ptr
    );

    modport slave (
        input  dest_valid, dest, in_valid, in_eop,
        output grant, egress_busy, egress_owner, timeout_err, drop,
        output dbg_state, dbg_rr_ptr
    );
endinterface

// File: rtl/egress_scheduler.sv
// Packet-level crossbar scheduler: per-ingress IDLE/WAIT/ACTIVE FSMs and an
// independent round-robin arbiter per egress; owners hold until eop or idle timeout.
module egress_scheduler #(
    parameter int NUM_PORTS = 4,
    parameter int TIMEOUT   = 64
) (
    input logic               clk,
    input logic               reset,
    egress_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_e                    state_q [NUM_PORTS];
    state_e                    state_d [NUM_PORTS];
    logic [NUM_PORTS-1:0][1:0] pdest_q, pdest_d;
    logic [NUM_PORTS-1:0][7:0] cnt_q, cnt_d;
    logic [NUM_PORTS-1:0][1:0] rr_q, rr_d;
    logic [NUM_PORTS-1:0]      busy_q, busy_d;
    logic [NUM_PORTS-1:0][1:0] owner_q, owner_d;
    logic [NUM_PORTS-1:0]      grant_q, grant_d;
    logic [NUM_PORTS-1:0]      timeout_q, timeout_d;
    logic [NUM_PORTS-1:0]      drop_q, drop_d;

    logic [NUM_PORTS-1:0]      release_v;
    logic [NUM_PORTS-1:0]      to_hit;
    logic [NUM_PORTS-1:0]      win;
    logic [1:0]                cand;

    // An owner gives up its egress on eop, or when this idle cycle would bring
    // the counter to TIMEOUT; eop takes priority over a coincident timeout.
    always_comb begin
        release_v = '0;
        to_hit    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (state_q[i] == ST_ACTIVE) begin
                if (bus.in_valid[i] && bus.in_eop[i]) begin
                    release_v[i] = 1'b1;
                end else if (!bus.in_valid[i] && (cnt_q[i] + 8'd1 >= TIMEOUT_C)) begin
                    release_v[i] = 1'b1;
                    to_hit[i]    = 1'b1;
                end
            end
        end
    end

    // Free egresses scan WAIT ingresses from rr_q; busy_d doubles as the
    // "already granted" flag so only the first candidate in scan order wins.
    always_comb begin
        win     = '0;
        busy_d  = busy_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cand    = '0;
        for (int e = 0; e < NUM_PORTS; e++) begin
            if (!busy_q[e]) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    cand = rr_q[e] + 2'(k);
                    if (!busy_d[e] && state_q[cand] == ST_WAIT && pdest_q[cand] == 2'(e)) begin
                        busy_d[e]  = 1'b1;
                        owner_d[e] = cand;
                        rr_d[e]    = cand + 2'd1;
                        win[cand]  = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (release_v[i]) begin
                busy_d[pdest_q[i]]  = 1'b0;
                owner_d[pdest_q[i]] = '0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            state_d[i]   = state_q[i];
            pdest_d[i]   = pdest_q[i];
            cnt_d[i]     = cnt_q[i];
            drop_d[i]    = 1'b0;
            timeout_d[i] = to_hit[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (bus.dest_valid[i]) begin
                        pdest_d[i] = bus.dest[i];
                        state_d[i] = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    drop_d[i] = bus.dest_valid[i];
                    if (win[i]) begin
                        state_d[i] = ST_ACTIVE;
                        cnt_d[i]   = '0;
                    end
                end
                ST_ACTIVE: begin
                    drop_d[i] = bus.dest_valid[i] && !(bus.in_valid[i] && bus.in_eop[i]);
                    if (release_v[i]) begin
                        // Only an eop release may chain straight into a new request.
                        if (!to_hit[i] && bus.dest_valid[i]) begin
                            state_d[i] = ST_WAIT;
                            pdest_d[i] = bus.dest[i];
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end else if (bus.in_valid[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] < TIMEOUT_C) begin
                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
            grant_d[i] = (state_d[i] == ST_ACTIVE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= ST_IDLE;
            end
            pdest_q   <= '0;
            cnt_q     <= '0;
            rr_q      <= '0;
            busy_q    <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            timeout_q <= '0;
            drop_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= state_d[i];
            end
            pdest_q   <= pdest_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            busy_q    <= busy_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.egress_busy  = busy_q;
    assign bus.egress_owner = owner_q;
    assign bus.timeout_err  = timeout_q;
    assign bus.drop         = drop_q;
    assign bus.dbg_rr_ptr   = rr_q;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_dbg
        assign bus.dbg_state[g] = state_q[g];
    end
endmodule

// File: tb/tb_egress_scheduler.sv
// Directed bench for egress_scheduler (TIMEOUT=4): a negedge monitor turns
// grant edges and status pulses into events and checks them against exp_q.
module tb_egress_scheduler;
  localparam int NP = 4;
  localparam int TO = 4;
  localparam int W  = 23;

  localparam logic [1:0] K_REL  = 2'd0;
  localparam logic [1:0] K_GNT  = 2'd1;
  localparam logic [1:0] K_TO   = 2'd2;
  localparam logic [1:0] K_DROP = 2'd3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [NP-1:0] prev_grant = '0;

  egress_scheduler_if #(.NUM_PORTS(NP)) bus ();

  egress_scheduler #(.NUM_PORTS(NP), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] ev(input logic [1:0] kind, input logic [1:0] port,
                                      input logic [2:0] eg, input int c);
    return {kind, port, eg, 16'(c)};
  endfunction

  function automatic logic [2:0] owned_egress(input logic [1:0] i);
    logic [2:0] r = 3'b000;
    for (int e = 0; e < NP; e++)
      if (bus.egress_busy[e] && bus.egress_owner[e] == i) r = {1'b1, 2'(e)};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [NP-1:0] dv, input logic [NP-1:0] iv, input logic [NP-1:0] eo);
    bus.dest_valid = dv;
    bus.in_valid   = iv;
    bus.in_eop     = eo;
    @(posedge clk);
    #1;
    bus.dest_valid = '0;
    bus.in_valid   = '0;
    bus.in_eop     = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) drive('0, '0, '0);
    check("drain_pending_events", exp_q.size(), 0);
    exp_q.delete();
    drive('0, '0, '0);
    drive('0, '0, '0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic emit(input logic [W-1:0] got);
    logic [W-1:0] want;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got %0h expected none (cycle %0d)", got, cyc);
    end else begin
      want = exp_q.pop_front();
      check("event", got, want);
    end
  endtask

  always @(negedge clk) begin
    logic [NP-1:0] idle_owner_bits;
    for (int i = 0; i < NP; i++) begin
      if (prev_grant[i] && !bus.grant[i]) emit(ev(K_REL, 2'(i), owned_egress(2'(i)), cyc));
      if (!prev_grant[i] && bus.grant[i]) emit(ev(K_GNT, 2'(i), owned_egress(2'(i)), cyc));
      if (bus.timeout_err[i]) emit(ev(K_TO, 2'(i), 3'b000, cyc));
      if (bus.drop[i]) emit(ev(K_DROP, 2'(i), 3'b000, cyc));
    end
    idle_owner_bits = '0;
    for (int e = 0; e < NP; e++)
      if (!bus.egress_busy[e]) idle_owner_bits[e] = |bus.egress_owner[e];
    check("owner_zero_when_idle", idle_owner_bits, 0);
    prev_grant <= bus.grant;
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    logic [NP-1:0] dv, iv, eo;
    reset = 1'b1;
    bus.dest_valid = '0;
    bus.dest       = '0;
    bus.in_valid   = '0;
    bus.in_eop     = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    check("reset_grant", bus.grant, 0);
    check("reset_busy", bus.egress_busy, 0);
    check("reset_owner", bus.egress_owner, 0);
    check("reset_timeout_err", bus.timeout_err, 0);
    check("reset_drop", bus.drop, 0);
    check("reset_rr_ptr", bus.dbg_rr_ptr, 0);
    check("reset_state", bus.dbg_state, 0);

    // Single request: dest_valid at 5 -> grant at 7; eop at 20 -> clear at 21.
    while (cyc < 5) drive('0, '0, '0);
    bus.dest[1] = 2'd2;
    exp_q.push_back(ev(K_GNT, 2'd1, 3'b110, 7));
    exp_q.push_back(ev(K_REL, 2'd1, 3'b000, 21));
    drive(4'b0010, '0, '0);
    drive('0, '0, '0);
    check("s1_grant_at_7", bus.grant, 4'b0010);
    check("s1_busy_at_7", bus.egress_busy, 4'b0100);
    check("s1_owner2_at_7", bus.egress_owner[2], 1);
    for (int k = 7; k < 20; k++) drive('0, 4'b0010, '0);
    drive('0, 4'b0010, 4'b0010);
    check("s1_grant_at_21", bus.grant, 0);
    check("s1_busy_at_21", bus.egress_busy, 0);
    check("s1_owner_at_21", bus.egress_owner, 0);
    drain();

    // Three ingresses contend for egress 0 with 4-word packets; 0 re-requests on its eop.
    c = cyc;
    bus.dest = '0;
    exp_q.push_back(ev(K_GNT, 2'd0, 3'b100, c + 2));
    exp_q.push_back(ev(K_REL, 2'd0, 3'b000, c + 6));
    exp_q.push_back(ev(K_GNT, 2'd1, 3'b100, c + 7));
    exp_q.push_back(ev(K_REL, 2'd1, 3'b000, c + 11));
    exp_q.push_back(ev(K_GNT, 2'd3, 3'b100, c + 12));
    exp_q.push_back(ev(K_REL, 2'd3, 3'b000, c + 16));
    exp_q.push_back(ev(K_GNT, 2'd0, 3'b100, c + 17));
    exp_q.push_back(ev(K_REL, 2'd0, 3'b000, c + 21));
    for (int k = 0; k < 22; k++) begin
      if (k == 2)  check("s2_rr0_after_g0", bus.dbg_rr_ptr[0], 1);
      if (k == 6)  check("s2_unowned_gap", bus.egress_busy[0], 0);
      if (k == 7)  check("s2_rr0_after_g1", bus.dbg_rr_ptr[0], 2);
      if (k == 12) check("s2_rr0_after_g3", bus.dbg_rr_ptr[0], 0);
      if (k == 17) check("s2_rr0_after_g0b", bus.dbg_rr_ptr[0], 1);
      dv = '0; iv = '0; eo = '0;
      if (k == 0) dv = 4'b1011;
      if (k >= 2 && k <= 5)   iv[0] = 1'b1;
      if (k == 5)             begin eo[0] = 1'b1; dv[0] = 1'b1; end
      if (k >= 7 && k <= 10)  iv[1] = 1'b1;
      if (k == 10)            eo[1] = 1'b1;
      if (k >= 12 && k <= 15) iv[3] = 1'b1;
      if (k == 15)            eo[3] = 1'b1;
      if (k >= 17 && k <= 20) iv[0] = 1'b1;
      if (k == 20)            eo[0] = 1'b1;
      drive(dv, iv, eo);
    end
    drain();

    // Independent egresses granted in the same cycle.
    c = cyc;
    bus.dest[0] = 2'd1;
    bus.dest[2] = 2'd3;
    exp_q.push_back(ev(K_GNT, 2'd0, 3'b101, c + 2));
    exp_q.push_back(ev(K_GNT, 2'd2, 3'b111, c + 2));
    exp_q.push_back(ev(K_REL, 2'd0, 3'b000, c + 4));
    exp_q.push_back(ev(K_REL, 2'd2, 3'b000, c + 5));
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        check("s3_grant_pair", bus.grant, 4'b0101);
        check("s3_busy_pair", bus.egress_busy, 4'b1010);
        check("s3_owner1", bus.egress_owner[1], 0);
        check("s3_owner3", bus.egress_owner[3], 2);
      end
      dv = '0; iv = '0; eo = '0;
      if (k == 0) dv = 4'b0101;
      if (k == 2) iv = 4'b0101;
      if (k == 3) begin iv = 4'b0101; eo[0] = 1'b1; end
      if (k == 4) begin iv[2] = 1'b1; eo[2] = 1'b1; end
      drive(dv, iv, eo);
    end
    drain();

    // Timeout on ingress 2, waiting ingress 1 takes over; then eop beats a would-be timeout.
    c = cyc;
    bus.dest[2] = 2'd0;
    bus.dest[1] = 2'd0;
    exp_q.push_back(ev(K_GNT, 2'd2, 3'b100, c + 2));
    exp_q.push_back(ev(K_REL, 2'd2, 3'b000, c + 6));
    exp_q.push_back(ev(K_TO,  2'd2, 3'b000, c + 6));
    exp_q.push_back(ev(K_GNT, 2'd1, 3'b100, c + 7));
    exp_q.push_back(ev(K_REL, 2'd1, 3'b000, c + 11));
    for (int k = 0; k < 13; k++) begin
      if (k == 2) check("s4_rr0_after_g2", bus.dbg_rr_ptr[0], 3);
      if (k == 5) check("s4_grant_last_cycle", bus.grant[2], 1);
      if (k == 6) check("s4_grant_revoked", bus.grant[2], 0);
      if (k == 7) check("s4_rr0_after_g1", bus.dbg_rr_ptr[0], 2);
      dv = '0; iv = '0; eo = '0;
      if (k == 0) dv[2] = 1'b1;
      if (k == 1) dv[1] = 1'b1;
      if (k == 10) begin iv[1] = 1'b1; eo[1] = 1'b1; end
      drive(dv, iv, eo);
    end
    drain();

    // Drops in ACTIVE and WAIT; dest_valid on the eop cycle re-requests without a drop.
    c = cyc;
    bus.dest[0] = 2'd2;
    bus.dest[3] = 2'd2;
    exp_q.push_back(ev(K_GNT,  2'd0, 3'b110, c + 2));
    exp_q.push_back(ev(K_DROP, 2'd0, 3'b000, c + 4));
    exp_q.push_back(ev(K_DROP, 2'd3, 3'b000, c + 5));
    exp_q.push_back(ev(K_REL,  2'd0, 3'b000, c + 7));
    exp_q.push_back(ev(K_GNT,  2'd3, 3'b110, c + 8));
    exp_q.push_back(ev(K_REL,  2'd3, 3'b000, c + 10));
    exp_q.push_back(ev(K_GNT,  2'd3, 3'b101, c + 11));
    exp_q.push_back(ev(K_REL,  2'd3, 3'b000, c + 13));
    for (int k = 0; k < 14; k++) begin
      dv = '0; iv = '0; eo = '0;
      if (k == 0) dv[0] = 1'b1;
      if (k >= 2 && k <= 6) iv[0] = 1'b1;
      if (k == 2) dv[3] = 1'b1;
      if (k == 3) dv[0] = 1'b1;
      if (k == 4) begin bus.dest[3] = 2'd1; dv[3] = 1'b1; end
      if (k == 6) eo[0] = 1'b1;
      if (k == 8) iv[3] = 1'b1;
      if (k == 9) begin iv[3] = 1'b1; eo[3] = 1'b1; dv[3] = 1'b1; end
      if (k == 11) iv[3] = 1'b1;
      if (k == 12) begin iv[3] = 1'b1; eo[3] = 1'b1; end
      drive(dv, iv, eo);
    end
    drain();

    // Reset with three owners active, then arbitration restarts from rr_ptr = 0.
    c = cyc;
    bus.dest[0] = 2'd0;
    bus.dest[1] = 2'd1;
    bus.dest[2] = 2'd2;
    exp_q.push_back(ev(K_GNT, 2'd0, 3'b100, c + 2));
    exp_q.push_back(ev(K_GNT, 2'd1, 3'b101, c + 2));
    exp_q.push_back(ev(K_GNT, 2'd2, 3'b110, c + 2));
    exp_q.push_back(ev(K_REL, 2'd0, 3'b000, c + 4));
    exp_q.push_back(ev(K_REL, 2'd1, 3'b000, c + 4));
    exp_q.push_back(ev(K_REL, 2'd2, 3'b000, c + 4));
    exp_q.push_back(ev(K_GNT, 2'd0, 3'b110, c + 7));
    exp_q.push_back(ev(K_REL, 2'd0, 3'b000, c + 8));
    exp_q.push_back(ev(K_GNT, 2'd3, 3'b110, c + 9));
    exp_q.push_back(ev(K_REL, 2'd3, 3'b000, c + 10));
    for (int k = 0; k < 12; k++) begin
      if (k == 2) check("s6_rr2_before_reset", bus.dbg_rr_ptr[2], 3);
      if (k == 3) reset = 1'b1;
      if (k == 4) begin
        reset = 1'b0;
        check("s6_reset_grant", bus.grant, 0);
        check("s6_reset_busy", bus.egress_busy, 0);
        check("s6_reset_owner", bus.egress_owner, 0);
        check("s6_reset_timeout_err", bus.timeout_err, 0);
        check("s6_reset_rr_ptr", bus.dbg_rr_ptr, 0);
        check("s6_reset_state", bus.dbg_state, 0);
      end
      dv = '0; iv = '0; eo = '0;
      if (k == 0) dv = 4'b0111;
      if (k == 2 || k == 3) iv = 4'b0111;
      if (k == 5) begin bus.dest[0] = 2'd2; bus.dest[3] = 2'd2; dv = 4'b1001; end
      if (k == 7) begin iv[0] = 1'b1; eo[0] = 1'b1; end
      if (k == 9) begin iv[3] = 1'b1; eo[3] = 1'b1; end
      drive(dv, iv, eo);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
